// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes and raises the decode stall for RAW, WAW and capacity hazards
module hazard_scoreboard #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 4,
  parameter int MAX_LAT = 4,
  parameter int CNT_W   = $clog2(MAX_LAT + 1),
  parameter int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic                 issue_we,
  input  logic [ADDR_W-1:0]    issue_waddr,
  input  logic [CNT_W-1:0]     issue_lat,
  input  logic [ADDR_W-1:0]    rs_addr,
  input  logic [ADDR_W-1:0]    rt_addr,
  input  logic                 rs_used,
  input  logic                 rt_used,
  input  logic                 flush,
  output logic                 stall,
  output logic                 raw_hazard,
  output logic                 waw_hazard,
  output logic                 full,
  output logic [OCC_W-1:0]     occupancy,
  output logic [2**ADDR_W-1:0] pending
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DEPTH-1:0]    r_valid;
  logic [ADDR_W-1:0]   r_waddr [DEPTH];
  logic [CNT_W-1:0]    r_cnt   [DEPTH];
  logic [CNT_W-1:0]    w_lat;
  logic                w_need;
  logic                w_alloc;
  logic                w_rs_hit;
  logic                w_rt_hit;
  logic                w_waw_hit;
  logic                w_free_found;
  logic [IDX_W-1:0]    w_free_idx;
  logic [OCC_W-1:0]    w_occ;
  logic [2**ADDR_W-1:0] w_pending;
  assign w_lat      = (issue_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : issue_lat;
  assign w_need     = issue_we & (issue_waddr != '0) & (w_lat != '0);
  assign raw_hazard = (rs_used & (rs_addr != '0) & w_rs_hit) | (rt_used & (rt_addr != '0) & w_rt_hit);
  assign waw_hazard = issue_we & (issue_waddr != '0) & w_waw_hit;
  assign full       = &r_valid;
  assign stall      = issue_valid & (raw_hazard | waw_hazard | (full & w_need));
  assign w_alloc    = issue_valid & ~stall & ~flush & w_need & w_free_found;
  assign occupancy  = w_occ;
  assign pending    = w_pending;
  // Scan entries for operand matches, late-completing same-destination writes, occupancy and the lowest free slot
  always_comb begin
    w_rs_hit     = 1'b0;
    w_rt_hit     = 1'b0;
    w_waw_hit    = 1'b0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_occ        = '0;
    w_pending    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
        w_rs_hit  = w_rs_hit  | (r_waddr[i] == rs_addr);
        w_rt_hit  = w_rt_hit  | (r_waddr[i] == rt_addr);
        w_waw_hit = w_waw_hit | ((r_waddr[i] == issue_waddr) & (r_cnt[i] > w_lat));
        w_occ     = w_occ + OCC_W'(1);
        w_pending[r_waddr[i]] = 1'b1;
      end else if (!w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
    w_pending[0] = 1'b0;
  end
  // Entry update: flush wins, otherwise allocate into the chosen free slot and count down the rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_waddr[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc && w_free_idx == IDX_W'(i)) begin
          r_valid[i] <= 1'b1;
          r_waddr[i] <= issue_waddr;
          r_cnt[i]   <= w_lat;
        end else if (r_valid[i]) begin
          if (r_cnt[i] <= CNT_W'(1)) r_valid[i] <= 1'b0;
          else r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end
endmodule
